// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited imem requests, in-order response FIFO, IF/ID register.
// Define FETCH_BUBBLE_CNT_EN to add the bubble_count output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic [31:0] pc_branch_dest,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic [31:0] instruction,
  output logic        valid
`ifdef FETCH_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubble_count
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [31:0]   dropCnt_q, dropCnt_d;
  logic [31:0]   dropSum;

  logic [31:0]   fifoPc_q    [BUF_DEPTH];
  logic [31:0]   fifoInstr_q [BUF_DEPTH];
  logic [PW-1:0] fifoRd_q, fifoRd_d, fifoWr_q, fifoWr_d;
  logic [CW-1:0] fifoCount_q, fifoCount_d;

  logic [31:0]   shadowPc_q [BUF_DEPTH];
  logic [PW-1:0] shadowRd_q, shadowRd_d, shadowWr_q, shadowWr_d;

  logic [31:0]   pc_q, pc_d, pc4_q, pc4_d, instr_q, instr_d;
  logic          valid_q, valid_d;

  logic          accept, rspGood, loadIfId, takeFifo, bypass, bubble, fifoPush;
  logic [1:0]    unusedDestBits;

  assign unusedDestBits = pc_branch_dest[1:0];

  // Outstanding requests (dropped ones included) plus buffered entries never exceed the FIFO depth.
  assign imem_req_valid = (({1'b0, outstanding_q} + {1'b0, fifoCount_q}) < DEPTH_W) && !pc_src;
  assign imem_req_addr  = fpc_q;

  always_comb begin
    accept   = imem_req_valid && imem_req_ready;
    rspGood  = imem_rsp_valid && !pc_src && (dropCnt_q == '0);
    loadIfId = !stall || !valid_q;
    takeFifo = !pc_src && loadIfId && (fifoCount_q != '0);
    bypass   = !pc_src && loadIfId && (fifoCount_q == '0) && rspGood;
    bubble   = !pc_src && loadIfId && (fifoCount_q == '0) && !rspGood;
    fifoPush = rspGood && !bypass;
  end

  always_comb begin
    fpc_d         = fpc_q;
    dropCnt_d     = dropCnt_q;
    dropSum       = dropCnt_q + 32'(outstanding_q);
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    fifoRd_d      = fifoRd_q;
    fifoWr_d      = fifoWr_q;
    fifoCount_d   = fifoCount_q;
    shadowRd_d    = shadowRd_q;
    shadowWr_d    = shadowWr_q;
    pc_d          = pc_q;
    pc4_d         = pc4_q;
    instr_d       = instr_q;
    valid_d       = valid_q;

    if (pc_src) begin
      fpc_d       = {pc_branch_dest[31:2], 2'b00};
      dropCnt_d   = (imem_rsp_valid && (dropSum != '0)) ? dropSum - 32'd1 : dropSum;
      fifoRd_d    = '0;
      fifoWr_d    = '0;
      fifoCount_d = '0;
      shadowRd_d  = '0;
      shadowWr_d  = '0;
      valid_d     = 1'b0;
      instr_d     = NOP_INSTR;
    end else begin
      if (accept) begin
        fpc_d      = fpc_q + 32'd4;
        shadowWr_d = shadowWr_q + PW'(1);
      end
      if (imem_rsp_valid && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - 32'd1;
      if (rspGood) shadowRd_d = shadowRd_q + PW'(1);
      if (fifoPush) fifoWr_d = fifoWr_q + PW'(1);
      if (takeFifo) fifoRd_d = fifoRd_q + PW'(1);
      fifoCount_d = fifoCount_q + CW'(fifoPush) - CW'(takeFifo);

      if (takeFifo) begin
        pc_d    = fifoPc_q[fifoRd_q];
        pc4_d   = fifoPc_q[fifoRd_q] + 32'd4;
        instr_d = fifoInstr_q[fifoRd_q];
        valid_d = 1'b1;
      end else if (bypass) begin
        pc_d    = shadowPc_q[shadowRd_q];
        pc4_d   = shadowPc_q[shadowRd_q] + 32'd4;
        instr_d = imem_rsp_data;
        valid_d = 1'b1;
      end else if (bubble) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q         <= RESET_PC;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
      fifoRd_q      <= '0;
      fifoWr_q      <= '0;
      fifoCount_q   <= '0;
      shadowRd_q    <= '0;
      shadowWr_q    <= '0;
      pc_q          <= '0;
      pc4_q         <= '0;
      instr_q       <= NOP_INSTR;
      valid_q       <= 1'b0;
    end else begin
      fpc_q         <= fpc_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
      fifoRd_q      <= fifoRd_d;
      fifoWr_q      <= fifoWr_d;
      fifoCount_q   <= fifoCount_d;
      shadowRd_q    <= shadowRd_d;
      shadowWr_q    <= shadowWr_d;
      pc_q          <= pc_d;
      pc4_q         <= pc4_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
    end
  end

  // Storage arrays carry no reset; their occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (fifoPush) begin
      fifoPc_q[fifoWr_q]    <= shadowPc_q[shadowRd_q];
      fifoInstr_q[fifoWr_q] <= imem_rsp_data;
    end
    if (accept) shadowPc_q[shadowWr_q] <= fpc_q;
  end

  assign pc          = pc_q;
  assign pc_plus_4   = pc4_q;
  assign instruction = instr_q;
  assign valid       = valid_q;

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubbleCount_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bubbleCount_q <= '0;
    else if (bubble) bubbleCount_q <= bubbleCount_q + 32'd1;
  end

  assign bubble_count = bubbleCount_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order tagged memory model plus an
// instruction-stream reference model, directed scenarios followed by random traffic.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] pc_branch_dest = '0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] pc, pc_plus_4, instruction;
  logic        valid;
`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubbleCount;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .pc_branch_dest(pc_branch_dest),
    .stall(stall), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pc(pc), .pc_plus_4(pc_plus_4),
    .instruction(instruction), .valid(valid)
`ifdef FETCH_BUBBLE_CNT_EN
    , .bubble_count(bubbleCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int due; int epoch; } memReq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } fetched_t;

  memReq_t  memQ[$];
  fetched_t avail[$];

  int          assertCount = 0;
  int          failCount = 0;
  int          cycle = 0;
  int          epoch = 0;
  int          memLat = 1;
  int          expBubbles = 0;
  logic [31:0] modelFpc, expPc, expPc4, expInstr, lastAccAddr;
  logic        expValid, lastReqValid, lastAccept;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1357};
  endfunction

  function automatic int pendingDrops();
    int n = 0;
    foreach (memQ[i]) if (memQ[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: check IF/ID against the model, drive inputs and memory, advance the model.
  task automatic applyStimulus(input logic pcSrcIn, input logic [31:0] destIn,
                               input logic stallIn, input logic readyIn);
    memReq_t  head;
    memReq_t  req;
    fetched_t f;
    logic     rspOn, good, load;
    checkOutput("pc", pc, expPc);
    checkOutput("pc_plus_4", pc_plus_4, expPc4);
    checkOutput("instruction", instruction, expInstr);
    checkOutput("valid", 32'(valid), 32'(expValid));
`ifdef FETCH_BUBBLE_CNT_EN
    checkOutput("bubble_count", bubbleCount, 32'(expBubbles));
`endif
    pc_src         = pcSrcIn;
    pc_branch_dest = destIn;
    stall          = stallIn;
    imem_req_ready = readyIn;
    rspOn          = (memQ.size() > 0) && (memQ[0].due <= cycle);
    imem_rsp_valid = rspOn;
    imem_rsp_data  = rspOn ? memQ[0].data : $urandom;
    #1;
    lastReqValid = imem_req_valid;
    if (pcSrcIn) checkOutput("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
    if (imem_req_valid) checkOutput("req_addr", imem_req_addr, modelFpc);
    lastAccept = imem_req_valid && readyIn;
    good = 1'b0;
    if (rspOn) begin
      head = memQ.pop_front();
      good = !pcSrcIn && (head.epoch == epoch);
    end
    if (pcSrcIn) begin
      epoch++;
      avail.delete();
      expValid = 1'b0;
      expInstr = NOP;
      modelFpc = {destIn[31:2], 2'b00};
    end else begin
      load = !stallIn || !expValid;
      if (good) begin
        f.pc = head.addr;
        f.instr = head.data;
        avail.push_back(f);
      end
      if (load) begin
        if (avail.size() > 0) begin
          f = avail.pop_front();
          expPc = f.pc;
          expPc4 = f.pc + 32'd4;
          expInstr = f.instr;
          expValid = 1'b1;
        end else begin
          expValid = 1'b0;
          expInstr = NOP;
          expBubbles++;
        end
      end
    end
    if (lastAccept) begin
      req.addr = imem_req_addr;
      req.data = memData(imem_req_addr);
      req.due = cycle + memLat;
      req.epoch = epoch;
      memQ.push_back(req);
      lastAccAddr = imem_req_addr;
      modelFpc = modelFpc + 32'd4;
    end
    checkOutput("credit_bound", 32'(memQ.size() + avail.size() <= DEPTH), 32'd1);
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Asserts reset between clock edges; memory is reset together with the fetch unit.
  task automatic applyReset();
    pc_src = 1'b0;
    stall = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    memQ.delete();
    avail.delete();
    epoch++;
    modelFpc = RESET_PC;
    expPc = '0;
    expPc4 = '0;
    expInstr = NOP;
    expValid = 1'b0;
    expBubbles = 0;
    checkOutput("rst_pc", pc, 32'd0);
    checkOutput("rst_pc_plus_4", pc_plus_4, 32'd0);
    checkOutput("rst_instruction", instruction, NOP);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
    @(posedge clk);
    #1;
    cycle++;
    reset = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic sawValid;
    logic [31:0] prevAcc;
    #1;
    applyReset();

    $display("[TB] reset and stream");
    memLat = 1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("first_req_valid", 32'(lastReqValid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
      checkOutput("stream_valid", 32'(valid), 32'd1);
      checkOutput("stream_pc", pc, RESET_PC + 32'(4 * i));
      checkOutput("stream_req_valid", 32'(lastReqValid), 32'd1);
    end

    $display("[TB] stall hold");
    idleCycles(12);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("stall_start_pc", pc, 32'h200);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
      checkOutput("stall_hold_pc", pc, 32'h200);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("stall_release_pc0", pc, 32'h204);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("stall_release_pc1", pc, 32'h208);

    $display("[TB] redirect with in-flight responses");
    idleCycles(12);
    memLat = 3;
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
    checkOutput("redirect_valid", 32'(valid), 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 15 && !sawValid; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
      if (valid) begin
        sawValid = 1'b1;
        checkOutput("redirect_first_pc", pc, 32'h40);
      end
    end
    checkOutput("redirect_target_seen", 32'(sawValid), 32'd1);

    $display("[TB] redirect with stall and misaligned target");
    memLat = 1;
    idleCycles(12);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h83, 1'b1, 1'b1);
    checkOutput("redirect_stall_valid", 32'(valid), 32'd0);
    checkOutput("redirect_stall_instr", instruction, NOP);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);

    $display("[TB] slow memory and wrap");
    idleCycles(12);
    memLat = 3;
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
    prevAcc = 32'h1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, logic'(i % 2 == 0));
      if (lastAccept) begin
        if (prevAcc == 32'hFFFF_FFFC) checkOutput("wrap_addr", lastAccAddr, 32'h0);
        prevAcc = lastAccAddr;
      end
    end

    $display("[TB] random traffic");
    for (int blk = 0; blk < 8; blk++) begin
      memLat = $urandom_range(1, 3);
      for (int i = 0; i < 50; i++) begin
        logic doRedirect;
        doRedirect = (pendingDrops() == 0) && ($urandom_range(0, 9) == 0);
        applyStimulus(doRedirect, $urandom, logic'($urandom_range(0, 9) < 3),
                      logic'($urandom_range(0, 9) < 7));
      end
    end

    $display("[TB] asynchronous reset mid-stream");
    memLat = 1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    applyReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("post_reset_pc", pc, RESET_PC + 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
